// File: rtl/bcd2bin.sv
// Two-digit BCD plus hundreds bit to 8-bit binary via reverse double-dabble; 9 clocks start to done.
// start is accepted only when idle or in the done state; start while busy is dropped, never queued.
module bcd2bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] d,
  input  logic       h,
  output logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [11:0] bcd;
  logic [7:0]  bin;
  logic [2:0]  cnt;
  logic        chk;

  logic [19:0] sh;
  logic [11:0] adj;

  // One reverse double-dabble step: shift right, then pull each nibble >= 8 back down by 3.
  always_comb begin
    sh  = {bcd, bin} >> 1;
    adj = sh[19:8];
    for (int i = 0; i < 3; i++) begin
      if (sh[8 + 4*i + 3]) begin
        adj[4*i +: 4] = sh[8 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bcd   <= '0;
      bin   <= '0;
      cnt   <= '0;
      chk   <= 1'b0;
      b     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // Status flags trail the state by one clock so every output stays a plain flop.
      busy <= (state == RUN);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            bcd   <= {3'b000, h, d};
            bin   <= '0;
            cnt   <= '0;
            chk   <= (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
            state <= RUN;
          end
        end
        RUN: begin
          bcd <= adj;
          bin <= sh[7:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DONE;
          end
        end
        DONE: begin
          b   <= chk ? 8'h00 : bin;
          err <= chk;
          if (start) begin
            bcd   <= {3'b000, h, d};
            bin   <= '0;
            cnt   <= '0;
            chk   <= (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Bench for bcd2bin: timeline reference model checked every cycle, plus directed literal cases.
`timescale 1ns/1ps
module tb_bcd2bin;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] d = 8'h00;
  logic       h = 1'b0;
  logic [7:0] b;
  logic       busy, done, err;

  bcd2bin dut (
    .clk(clk), .rst(rst), .start(start), .d(d), .h(h),
    .b(b), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted start at edge t0 owns edges t0+1..t0+9, result lands at t0+9.
  int         cyc = 0;
  int         t0 = 0;
  bit         active = 1'b0;
  bit         ready;
  logic [7:0] m_b = 8'h00;
  logic       m_err = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [7:0] pend_b = 8'h00;
  logic       pend_err = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
      m_b = 8'h00; m_err = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      ready  = !active || (cyc == t0 + 9);
      m_done = active && (cyc == t0 + 9);
      if (m_done) begin
        m_b = pend_b; m_err = pend_err; active = 1'b0;
      end
      m_busy = active && (cyc >= t0 + 1) && (cyc <= t0 + 8);
      if (start && ready) begin
        active   = 1'b1;
        t0       = cyc;
        pend_err = (d[7:4] > 9) || (d[3:0] > 9);
        pend_b   = pend_err ? 8'd0 : 8'(100 * int'(h) + 10 * int'(d[7:4]) + int'(d[3:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("b", 32'(b), 32'(m_b));
      check("err", 32'(err), 32'(m_err));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
    end
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // Single conversion with literal expectations; done must show on the 10th falling edge.
  task automatic conv(input logic hh, input logic [7:0] dd, input logic [7:0] exp_b, input logic exp_e);
    int n;
    @(negedge clk);
    h = hh; d = dd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; d = $urandom; h = $urandom;
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("lat", 32'(n), 32'd10);
    check("lit_b", 32'(b), 32'(exp_b));
    check("lit_err", 32'(err), 32'(exp_e));
    check("model_b", 32'(m_b), 32'(exp_b));
  endtask

  initial begin
    int n, dones;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    conv(1'b1, 8'h99, 8'hC7, 1'b0);
    conv(1'b0, 8'h42, 8'h2A, 1'b0);
    conv(1'b1, 8'h00, 8'h64, 1'b0);
    conv(1'b0, 8'h00, 8'h00, 1'b0);
    conv(1'b0, 8'h7A, 8'h00, 1'b1);
    conv(1'b0, 8'h15, 8'h0F, 1'b0);
    conv(1'b1, 8'h9F, 8'h00, 1'b1);

    // start pulses during busy cycles 3..5 must be ignored
    @(negedge clk);
    h = 1'b0; d = 8'h37; start = 1'b1;
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = (i >= 3 && i <= 5);
      d = (i >= 3 && i <= 5) ? 8'h88 : 8'h37;
      if (done) dones++;
      if (i == 10) check("pulse_b", 32'(b), 32'd37);
    end
    check("pulse_dones", 32'(dones), 32'd1);

    // start held through DONE: immediate reload, second done 9 clocks later
    @(negedge clk);
    h = 1'b0; d = 8'h10; start = 1'b1;
    wait_done("b2b1", n);
    start = 1'b0;
    check("b2b_first_b", 32'(b), 32'h0A);
    wait_done("b2b2", n);
    check("b2b_gap", 32'(n), 32'd9);
    check("b2b_second_b", 32'(b), 32'h0A);

    // reset at busy cycle 4 aborts with no done
    @(negedge clk);
    h = 1'b1; d = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_b", 32'(b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_dones", 32'(dones), 32'd0);
    conv(1'b0, 8'h42, 8'h2A, 1'b0);

    // exhaustive valid inputs, back-to-back; item c encodes value c
    @(negedge clk);
    h = 1'b0; d = 8'h00; start = 1'b1;
    @(negedge clk);
    h = 1'b0; d = 8'h01;
    for (int c = 0; c < 200; c++) begin
      wait_done("exh", n);
      check("exh_gap", 32'(n), 32'd9);
      check("exh_b", 32'(b), 32'(c));
      check("exh_err", 32'(err), 32'd0);
      if (c + 2 < 200) begin
        h = ((c + 2) / 100) != 0;
        d = {4'(((c + 2) % 100) / 10), 4'((c + 2) % 10)};
      end else begin
        start = 1'b0;
      end
    end

    // random traffic including invalid digits, stray starts and resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom % 4) == 0;
      d = 8'($urandom);
      h = 1'($urandom);
      rst = ($urandom % 100) == 0;
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential BCD-to-binary converter: the consumer end of the BCD adder datapath. Takes a two-digit packed BCD value plus a hundreds carry bit, in the same form a two-digit BCD adder produces (0..199). Returns the equivalent 8-bit unsigned binary value using iterative reverse double-dabble. One conversion occupies 8 shift cycles under a start/busy/done handshake. Digits outside 0..9 are flagged.

## Interface
- No parameters; widths are fixed (2 BCD digits + hundreds bit in, 8-bit binary out).
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request conversion; sampled only when idle or done
- d  input  8  packed BCD operand: d[7:4] tens, d[3:0] ones
- h  input  1  hundreds digit (0 or 1), i.e. the BCD adder carry-out
- b  output  8  binary result, held until the next completion
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: b and err valid
- err  output  1  input digit > 9 detected for the completed conversion; valid with done, held with b

## Operation
- Internal state: 12-bit BCD shift register (nibbles H = {000,h}, T, O), 8-bit binary shift register, 3-bit step counter, FSM {IDLE, RUN, DONE}.
- IDLE: busy=0, done=0. When start=1, load BCD reg <= {3'b000,h,d}, clear binary reg and counter, latch digit-check flag (d[7:4]>9 or d[3:0]>9), go to RUN.
- RUN, each cycle:
  - shift the 20-bit concatenation {BCD, bin} right by 1; BCD bit 0 enters bin bit 7;
  - then, for each BCD nibble of the shifted value, if nibble >= 8 subtract 3 from it;
  - counter increments.
- After the 8th RUN cycle (counter wraps 7->0), go to DONE and update outputs: b <= binary reg (or 8'h00 if the check flag is set), err <= check flag.
- DONE: done=1 for exactly this cycle. With start=1, reload and go to RUN (back-to-back); otherwise go to IDLE.
- start while RUN: ignored, not queued. d/h are don't-care outside the load cycle.
- Arithmetic rules:
  - Valid inputs always yield b = 100*h + 10*d[7:4] + d[3:0], max 199, which fits 8 bits with no overflow.
  - The H nibble never reaches 8.
- err=1: conversion still runs the full 8 cycles (fixed latency), b forced to 0.
- rst (any state, including mid-RUN):
  - FSM to IDLE; b=0, busy=0, done=0, err=0; counter and shift registers cleared;
  - an aborted conversion produces no done pulse.

## Timing
- Reset values: b=8'h00, busy=0, done=0, err=0.
- start high at edge k (state IDLE or DONE): busy=1 in cycles k+1 .. k+8 (8 cycles).
- b, err update at edge k+9. done=1 in the cycle after edge k+9 only.
- Latency start-sample to done: 9 clocks. Throughput: one conversion per 9 clocks with back-to-back start held in DONE.
- busy and done are never high in the same cycle.
- b and err remain stable from the done cycle until the next done or rst.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: b=0, busy=0, done=0, err=0; start=0 for 20 cycles -> no change.
- h=1, d=8'h99 -> after 9 clocks done pulse, b=8'hC7 (199), err=0; h=0, d=8'h42 -> b=8'h2A; h=1, d=8'h00 -> b=8'h64; h=0, d=8'h00 -> b=8'h00.
- Invalid digit: h=0, d=8'h7A -> done after 9 clocks, err=1, b=8'h00. Next valid conversion d=8'h15 -> err=0, b=8'h0F.
- start pulsed again during busy cycles 3..5 -> ignored; single done with the original result. start held through DONE with d=8'h10 -> immediate reload, second done exactly 9 clocks later with b=8'h0A.
- rst asserted at busy cycle 4 of d=8'h99, h=1 -> next cycle all outputs at reset values, no done ever appears. A fresh start converts correctly.
- Exhaustive: all h in {0,1}, all valid d -> b equals decimal value and err=0; done spacing exactly 9 clocks.
